branch_target_unit: RTL

BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

---
 rtl/branch_target_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/branch_target_unit.sv
// Decode-side branch target unit: computes jump/branch targets and link
// addresses one cycle after decode, and keeps a circular return-address stack.
module branch_target_unit #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic                         stall,
   input  logic                         flush,
   input  logic [31:0]                  ins,
   input  logic [XLEN-1:0]              pc,
   input  logic [XLEN-1:0]              rs1_mod,
   input  logic                         comp_sig,
   input  logic [XLEN-1:0]              comp_imm,
   input  logic                         jal,
   input  logic                         jalr,
   input  logic                         branch,
   input  logic [4:0]                   rd_idx,
   input  logic [4:0]                   rs1_idx,
   output logic                         valid_out,
   output logic [XLEN-1:0]              target,
   output logic [XLEN-1:0]              link,
   output logic [XLEN-1:0]              ras_pred,
   output logic                         ras_hit,
   output logic [$clog2(RAS_DEPTH):0]   ras_count
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0]   sp_q, sp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            valid_q;
   logic [XLEN-1:0] target_q, target_d;
   logic [XLEN-1:0] link_q, link_d;
   logic [XLEN-1:0] pred_q, pred_d;
   logic            hit_q, hit_d;

   logic [XLEN-1:0] b_imm, j_imm, i_imm;
   logic [PW-1:0]   top_idx;
   logic            acc, rd_l, rs_l, nonempty;
   logic            do_push, do_pop;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;
   logic            ins_unused;

   assign ins_unused = ^ins[6:0];
   assign top_idx    = sp_q - PW'(1);
   assign nonempty   = (cnt_q != '0);
   assign acc        = valid_in & ~flush & ~stall;
   assign rd_l       = (rd_idx == 5'd1) || (rd_idx == 5'd5);
   assign rs_l       = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);

   // Immediate extraction, target and link computation
   always_comb begin
      b_imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
               ins[30:25], ins[11:8], 1'b0};
      j_imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12],
               ins[20], ins[30:21], 1'b0};
      i_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
      if (comp_sig) begin
         b_imm = comp_imm;
         j_imm = comp_imm;
         i_imm = comp_imm;
      end
      target_d = pc + b_imm;
      unique case (1'b1)
         jal:     target_d = pc + j_imm;
         jalr:    target_d = (rs1_mod + i_imm) & ~XLEN'(1);
         branch:  target_d = pc + b_imm;
         default: target_d = pc + b_imm;
      endcase
      link_d = pc + (comp_sig ? XLEN'(2) : XLEN'(4));
   end

   // Return-address-stack action decode and next-state
   always_comb begin
      do_push = 1'b0;
      do_pop  = 1'b0;
      if (acc && jal) begin
         do_push = rd_l;
      end else if (acc && jalr) begin
         do_push = rd_l;
         do_pop  = rs_l && !(rd_l && (rd_idx == rs1_idx));
      end
      hit_d  = do_pop && nonempty;
      pred_d = hit_d ? ras_q[top_idx] : pred_q;
      sp_d   = sp_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = sp_q;
      if (do_push && do_pop && nonempty) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (do_push) begin
         wr_en = 1'b1;
         sp_d  = sp_q + PW'(1);
         if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end else if (do_pop && nonempty) begin
         sp_d  = top_idx;
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Result and stack-pointer registers; stall holds everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         target_q <= '0;
         link_q   <= '0;
         pred_q   <= '0;
         hit_q    <= 1'b0;
         sp_q     <= '0;
         cnt_q    <= '0;
      end else if (!stall) begin
         valid_q  <= valid_in & ~flush;
         target_q <= target_d;
         link_q   <= link_d;
         pred_q   <= pred_d;
         hit_q    <= hit_d;
         sp_q     <= sp_d;
         cnt_q    <= cnt_d;
      end
   end

   // Stack storage; contents are only meaningful below the occupancy count
   always_ff @(posedge clk) begin
      if (wr_en) ras_q[wr_idx] <= link_d;
   end

   assign valid_out = valid_q;
   assign target    = target_q;
   assign link      = link_q;
   assign ras_pred  = pred_q;
   assign ras_hit   = hit_q;
   assign ras_count = cnt_q;

endmodule
